hazard_scoreboard: RTL and testbench

//  Parametrised forwarding and hazard unit for the in-order core pipeline.
//  - Selects an operand source for rs1/rs2 from NUM_FWD write-back sources
//    or the register file.
//  - Tracks up to PEND_DEPTH outstanding long-latency writes (loads, PIM ops)
//    in a registered pending table.
//  - Raises stall_o when a needed operand is in flight but not yet forwardable.
//  - Sits in ID, beside the register file read; drives the operand muxes and
//    the pipeline stall.

---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Operand forwarding select and hazard stall for the ID stage, with a pending
// table that tracks outstanding long-latency register writes.
module hazard_scoreboard #(
    parameter int NUM_FWD    = 3,
    parameter int PEND_DEPTH = 4,
    parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              id_valid_i,
    input  logic [6:0]                        opcode_i,
    input  logic [4:0]                        rs1_i,
    input  logic [4:0]                        rs2_i,
    input  logic [NUM_FWD-1:0]                fwd_we_i,
    input  logic [5*NUM_FWD-1:0]              fwd_rd_i,
    input  logic [NUM_FWD-1:0]                fwd_ready_i,
    input  logic                              issue_long_i,
    input  logic [4:0]                        issue_rd_i,
    input  logic                              complete_i,
    input  logic [4:0]                        complete_rd_i,
    output logic [SEL_W-1:0]                  forward_a_o,
    output logic [SEL_W-1:0]                  forward_b_o,
    output logic                              stall_o,
    output logic                              pend_full_o,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_count_o,
    output logic                              err_o
);
    localparam int CNT_W = $clog2(PEND_DEPTH + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_PIM    = 7'b0001011;

    logic [PEND_DEPTH-1:0]       pend_vld;
    logic [PEND_DEPTH-1:0]       pend_vld_cpl;
    logic [PEND_DEPTH-1:0]       pend_vld_nxt;
    logic [PEND_DEPTH-1:0][4:0]  pend_rd;
    logic [PEND_DEPTH-1:0][4:0]  pend_rd_nxt;
    logic                        err_q;
    logic                        err_nxt;
    logic                        cpl_hit;
    logic                        iss_done;

    logic                        rs1_used;
    logic                        rs2_used;
    logic                        use_a;
    logic                        use_b;
    logic [SEL_W-1:0]            sel_a;
    logic [SEL_W-1:0]            sel_b;
    logic                        rdy_a;
    logic                        rdy_b;
    logic                        hit_a;
    logic                        hit_b;
    logic [CNT_W-1:0]            cnt;

    always_comb begin
        rs1_used = !((opcode_i == OP_JAL) || (opcode_i == OP_LUI) || (opcode_i == OP_AUIPC));
        rs2_used = (opcode_i == OP_R) || (opcode_i == OP_STORE) ||
                   (opcode_i == OP_BRANCH) || (opcode_i == OP_PIM);
        use_a    = id_valid_i && rs1_used && (rs1_i != 5'd0);
        use_b    = id_valid_i && rs2_used && (rs2_i != 5'd0);
    end

    // Walk from oldest to youngest so the lowest-index match wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_rd_i[5*k +: 5] == rs1_i)) begin
                sel_a = SEL_W'(k + 1);
                rdy_a = fwd_ready_i[k];
            end
            if (fwd_we_i[k] && (fwd_rd_i[5*k +: 5] == rs2_i)) begin
                sel_b = SEL_W'(k + 1);
                rdy_b = fwd_ready_i[k];
            end
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        cnt   = '0;
        for (int e = 0; e < PEND_DEPTH; e++) begin
            if (pend_vld[e] && (pend_rd[e] == rs1_i)) hit_a = 1'b1;
            if (pend_vld[e] && (pend_rd[e] == rs2_i)) hit_b = 1'b1;
            cnt = cnt + CNT_W'(pend_vld[e]);
        end
    end

    assign forward_a_o  = use_a ? sel_a : '0;
    assign forward_b_o  = use_b ? sel_b : '0;
    assign stall_o      = (use_a && (!rdy_a || hit_a)) || (use_b && (!rdy_b || hit_b));
    assign pend_full_o  = &pend_vld;
    assign pend_count_o = cnt;
    assign err_o        = err_q;

    // Completion is applied before issue so a full table can accept a new write.
    always_comb begin
        pend_vld_cpl = pend_vld;
        pend_rd_nxt  = pend_rd;
        err_nxt      = err_q;
        cpl_hit      = 1'b0;
        iss_done     = 1'b0;
        if (complete_i) begin
            for (int e = 0; e < PEND_DEPTH; e++) begin
                if (!cpl_hit && pend_vld[e] && (pend_rd[e] == complete_rd_i)) begin
                    pend_vld_cpl[e] = 1'b0;
                    cpl_hit         = 1'b1;
                end
            end
            if (!cpl_hit) err_nxt = 1'b1;
        end
        pend_vld_nxt = pend_vld_cpl;
        if (issue_long_i && (issue_rd_i != 5'd0)) begin
            for (int e = 0; e < PEND_DEPTH; e++) begin
                if (!iss_done && !pend_vld_cpl[e]) begin
                    pend_vld_nxt[e] = 1'b1;
                    pend_rd_nxt[e]  = issue_rd_i;
                    iss_done        = 1'b1;
                end
            end
            if (!iss_done) err_nxt = 1'b1;
        end
    end

    // Table registers: valid/error are control and reset; rd is data only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_vld <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_vld <= pend_vld_nxt;
            err_q    <= err_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        pend_rd <= pend_rd_nxt;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding priority, load-use stall,
// pending-table lifecycle, overflow/underflow errors and asynchronous reset.
module tb_hazard_scoreboard;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  fwd_we_i;
    logic [14:0] fwd_rd_i;
    logic [2:0]  fwd_ready_i;
    logic        issue_long_i;
    logic [4:0]  issue_rd_i;
    logic        complete_i;
    logic [4:0]  complete_rd_i;
    logic [1:0]  forward_a_o;
    logic [1:0]  forward_b_o;
    logic        stall_o;
    logic        pend_full_o;
    logic [2:0]  pend_count_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;

    hazard_scoreboard #(.NUM_FWD(3), .PEND_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
        .opcode_i(opcode_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .fwd_we_i(fwd_we_i), .fwd_rd_i(fwd_rd_i), .fwd_ready_i(fwd_ready_i),
        .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
        .complete_i(complete_i), .complete_rd_i(complete_rd_i),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
        .stall_o(stall_o), .pend_full_o(pend_full_o),
        .pend_count_o(pend_count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        id_valid_i    = 1'b0;
        opcode_i      = OP_R;
        rs1_i         = 5'd0;
        rs2_i         = 5'd0;
        fwd_we_i      = 3'b000;
        fwd_rd_i      = '0;
        fwd_ready_i   = 3'b111;
        issue_long_i  = 1'b0;
        issue_rd_i    = 5'd0;
        complete_i    = 1'b0;
        complete_rd_i = 5'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        idle();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd);
        @(negedge clk_i);
        idle();
        issue_long_i = 1'b1;
        issue_rd_i   = rd;
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        #3;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL rst_stall got %0b want 0", stall_o); end
        tests++; if (pend_count_o !== 3'd0) begin failed++; $display("FAIL rst_count got %0d want 0", pend_count_o); end
        tests++; if (pend_full_o !== 1'b0) begin failed++; $display("FAIL rst_full got %0b want 0", pend_full_o); end
        tests++; if (err_o !== 1'b0) begin failed++; $display("FAIL rst_err got %0b want 0", err_o); end
        tests++; if (forward_a_o !== 2'd0 || forward_b_o !== 2'd0) begin failed++; $display("FAIL rst_fwd got %0d/%0d want 0/0", forward_a_o, forward_b_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_forward();
        @(negedge clk_i);
        idle();
        id_valid_i = 1'b1; opcode_i = OP_R; rs1_i = 5'd1; rs2_i = 5'd2;
        fwd_we_i = 3'b101; fwd_rd_i = {5'd2, 5'd0, 5'd1}; fwd_ready_i = 3'b111;
        #2;
        tests++; if (forward_a_o !== 2'd1) begin failed++; $display("FAIL fwd_add_a got %0d want 1", forward_a_o); end
        tests++; if (forward_b_o !== 2'd3) begin failed++; $display("FAIL fwd_add_b got %0d want 3", forward_b_o); end
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL fwd_add_stall got %0b want 0", stall_o); end
        // two sources write x3: youngest (not ready) wins over older ready one
        @(negedge clk_i);
        rs1_i = 5'd3; rs2_i = 5'd0;
        fwd_we_i = 3'b011; fwd_rd_i = {5'd0, 5'd3, 5'd3}; fwd_ready_i = 3'b010;
        #2;
        tests++; if (forward_a_o !== 2'd1) begin failed++; $display("FAIL fwd_prio_a got %0d want 1", forward_a_o); end
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL fwd_prio_stall got %0b want 1", stall_o); end
        @(negedge clk_i);
        fwd_we_i = 3'b110; fwd_rd_i = {5'd3, 5'd3, 5'd9}; fwd_ready_i = 3'b101;
        #2;
        tests++; if (forward_a_o !== 2'd2) begin failed++; $display("FAIL fwd_prio2_a got %0d want 2", forward_a_o); end
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL fwd_prio2_stall got %0b want 1", stall_o); end
        @(negedge clk_i);
        opcode_i = OP_STORE; rs1_i = 5'd4; rs2_i = 5'd12;
        fwd_we_i = 3'b100; fwd_rd_i = {5'd12, 5'd0, 5'd0}; fwd_ready_i = 3'b111;
        #2;
        tests++; if (forward_a_o !== 2'd0 || forward_b_o !== 2'd3) begin failed++; $display("FAIL fwd_store got %0d/%0d want 0/3", forward_a_o, forward_b_o); end
    endtask

    task automatic test_load_use();
        @(negedge clk_i);
        idle();
        id_valid_i = 1'b1; opcode_i = OP_ADDI; rs1_i = 5'd5; rs2_i = 5'd5;
        fwd_we_i = 3'b001; fwd_rd_i = {5'd0, 5'd0, 5'd5}; fwd_ready_i = 3'b110;
        #2;
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL lu_stall got %0b want 1", stall_o); end
        tests++; if (forward_a_o !== 2'd1 || forward_b_o !== 2'd0) begin failed++; $display("FAIL lu_fwd got %0d/%0d want 1/0", forward_a_o, forward_b_o); end
        @(negedge clk_i);
        fwd_ready_i = 3'b111;
        #2;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL lu_release got %0b want 0", stall_o); end
        tests++; if (forward_a_o !== 2'd1) begin failed++; $display("FAIL lu_release_fwd got %0d want 1", forward_a_o); end
    endtask

    task automatic test_pending();
        @(negedge clk_i);
        idle();
        id_valid_i = 1'b1; opcode_i = OP_ADDI; rs1_i = 5'd7;
        issue_long_i = 1'b1; issue_rd_i = 5'd7;
        #2;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL pend_c0_stall got %0b want 0", stall_o); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            issue_long_i = 1'b0;
            complete_i = (c == 3); complete_rd_i = 5'd7;
            #2;
            tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL pend_c%0d_stall got %0b want 1", c, stall_o); end
            tests++; if (pend_count_o !== 3'd1) begin failed++; $display("FAIL pend_c%0d_count got %0d want 1", c, pend_count_o); end
        end
        @(negedge clk_i);
        complete_i = 1'b0;
        #2;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL pend_done_stall got %0b want 0", stall_o); end
        tests++; if (pend_count_o !== 3'd0) begin failed++; $display("FAIL pend_done_count got %0d want 0", pend_count_o); end
        tests++; if (err_o !== 1'b0) begin failed++; $display("FAIL pend_done_err got %0b want 0", err_o); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) issue(5'(i));
        #2;
        tests++; if (pend_full_o !== 1'b1 || pend_count_o !== 3'd4) begin failed++; $display("FAIL full_fill got full=%0b cnt=%0d want 1/4", pend_full_o, pend_count_o); end
        tests++; if (err_o !== 1'b0) begin failed++; $display("FAIL full_fill_err got %0b want 0", err_o); end
        issue(5'd5);
        id_valid_i = 1'b1; opcode_i = OP_ADDI; rs1_i = 5'd5;
        #2;
        tests++; if (err_o !== 1'b1) begin failed++; $display("FAIL full_ovf_err got %0b want 1", err_o); end
        tests++; if (pend_count_o !== 3'd4) begin failed++; $display("FAIL full_ovf_count got %0d want 4", pend_count_o); end
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL full_drop_stall got %0b want 0", stall_o); end
        // same-cycle complete+issue on a full table, from a clean error flag
        apply_reset();
        for (int i = 1; i <= 4; i++) issue(5'(i));
        @(negedge clk_i);
        complete_i = 1'b1; complete_rd_i = 5'd2; issue_long_i = 1'b1; issue_rd_i = 5'd9;
        @(negedge clk_i);
        idle();
        id_valid_i = 1'b1; opcode_i = OP_ADDI; rs1_i = 5'd9;
        #2;
        tests++; if (pend_count_o !== 3'd4 || pend_full_o !== 1'b1) begin failed++; $display("FAIL swap_count got %0d full=%0b want 4/1", pend_count_o, pend_full_o); end
        tests++; if (err_o !== 1'b0) begin failed++; $display("FAIL swap_err got %0b want 0", err_o); end
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL swap_x9_stall got %0b want 1", stall_o); end
        rs1_i = 5'd2;
        #1;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL swap_x2_stall got %0b want 0", stall_o); end
    endtask

    task automatic test_duplicate();
        apply_reset();
        issue(5'd6);
        issue(5'd6);
        @(negedge clk_i);
        complete_i = 1'b1; complete_rd_i = 5'd6;
        @(negedge clk_i);
        idle();
        id_valid_i = 1'b1; opcode_i = OP_R; rs1_i = 5'd0; rs2_i = 5'd6;
        #2;
        tests++; if (pend_count_o !== 3'd1 || stall_o !== 1'b1) begin failed++; $display("FAIL dup_one got cnt=%0d stall=%0b want 1/1", pend_count_o, stall_o); end
        complete_i = 1'b1; complete_rd_i = 5'd6;
        @(negedge clk_i);
        complete_i = 1'b0;
        #2;
        tests++; if (pend_count_o !== 3'd0 || stall_o !== 1'b0 || err_o !== 1'b0) begin failed++; $display("FAIL dup_two got cnt=%0d stall=%0b err=%0b want 0/0/0", pend_count_o, stall_o, err_o); end
    endtask

    task automatic test_unused();
        apply_reset();
        @(negedge clk_i);
        id_valid_i = 1'b1; opcode_i = OP_LUI; rs1_i = 5'd1; rs2_i = 5'd1;
        fwd_we_i = 3'b001; fwd_rd_i = {5'd0, 5'd0, 5'd1}; fwd_ready_i = 3'b000;
        #2;
        tests++; if (forward_a_o !== 2'd0 || forward_b_o !== 2'd0 || stall_o !== 1'b0) begin failed++; $display("FAIL lui got %0d/%0d stall=%0b want 0/0/0", forward_a_o, forward_b_o, stall_o); end
        @(negedge clk_i);
        opcode_i = OP_R; rs1_i = 5'd0; rs2_i = 5'd0; fwd_rd_i = '0;
        #2;
        tests++; if (forward_a_o !== 2'd0 || forward_b_o !== 2'd0 || stall_o !== 1'b0) begin failed++; $display("FAIL x0 got %0d/%0d stall=%0b want 0/0/0", forward_a_o, forward_b_o, stall_o); end
        @(negedge clk_i);
        id_valid_i = 1'b0; rs1_i = 5'd1; rs2_i = 5'd1; fwd_rd_i = {5'd0, 5'd0, 5'd1};
        #2;
        tests++; if (forward_a_o !== 2'd0 || forward_b_o !== 2'd0 || stall_o !== 1'b0) begin failed++; $display("FAIL novalid got %0d/%0d stall=%0b want 0/0/0", forward_a_o, forward_b_o, stall_o); end
        @(negedge clk_i);
        idle();
        complete_i = 1'b1; complete_rd_i = 5'd8;
        @(negedge clk_i);
        idle();
        #2;
        tests++; if (err_o !== 1'b1 || pend_count_o !== 3'd0) begin failed++; $display("FAIL undf got err=%0b cnt=%0d want 1/0", err_o, pend_count_o); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk_i);
        complete_i = 1'b1; complete_rd_i = 5'd20;
        @(negedge clk_i);
        idle();
        issue(5'd3);
        issue(5'd4);
        issue(5'd5);
        id_valid_i = 1'b1; opcode_i = OP_R; rs1_i = 5'd3; rs2_i = 5'd4;
        #2;
        tests++; if (stall_o !== 1'b1 || pend_count_o !== 3'd3 || err_o !== 1'b1) begin failed++; $display("FAIL arst_pre got stall=%0b cnt=%0d err=%0b want 1/3/1", stall_o, pend_count_o, err_o); end
        rst_ni = 1'b0;
        #1;
        tests++; if (pend_count_o !== 3'd0) begin failed++; $display("FAIL arst_count got %0d want 0", pend_count_o); end
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL arst_stall got %0b want 0", stall_o); end
        tests++; if (err_o !== 1'b0) begin failed++; $display("FAIL arst_err got %0b want 0", err_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_pending();
        test_full();
        test_duplicate();
        test_unused();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
